// File: rtl/lock_access_controller_if.sv
// Handshake bundle between the combination lock and its access controller.
// master drives the lock-side status inputs; slave is the controller itself.
interface lock_access_controller_if;
    logic       unlocked;
    logic       fail;
    logic       relock;
    logic       key_enable;
    logic       lock_clear;
    logic       alarm;
    logic [1:0] state;
    logic [1:0] fail_count;

    modport master (
        output unlocked, fail, relock,
        input  key_enable, lock_clear, alarm, state, fail_count
    );

    modport slave (
        input  unlocked, fail, relock,
        output key_enable, lock_clear, alarm, state, fail_count
    );
endinterface

// File: rtl/lock_access_controller.sv
// Access controller for a combination lock: gates keys, times the open window,
// and enforces a lockout after repeated failures. Optional macro: ALARM_LATCH_EN.
module lock_access_controller #(
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter int unsigned OPEN_CYCLES    = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    lock_access_controller_if.slave  bus_if
);

    localparam int unsigned TimerW = 8;
    localparam int unsigned CountW = 2;

    localparam logic [TimerW-1:0] OpenLoad    = TimerW'(OPEN_CYCLES - 1);
    localparam logic [TimerW-1:0] LockoutLoad = TimerW'(LOCKOUT_CYCLES - 1);
    localparam logic [CountW-1:0] FailLast    = CountW'(MAX_FAILS - 1);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'b00,
        ST_OPEN    = 2'b01,
        ST_RELOCK  = 2'b10,
        ST_LOCKOUT = 2'b11
    } state_e;

    state_e              state_q,      state_d;
    logic [CountW-1:0]   fail_count_q, fail_count_d;
    logic [TimerW-1:0]   timer_q,      timer_d;

    // Next-state logic; the timer is only loaded on entry and stops at zero.
    always_comb begin
        state_d      = state_q;
        fail_count_d = fail_count_q;
        timer_d      = timer_q;
        unique case (state_q)
            ST_ARMED: begin
                if (bus_if.unlocked) begin
                    state_d      = ST_OPEN;
                    fail_count_d = '0;
                    timer_d      = OpenLoad;
                end else if (bus_if.fail) begin
                    if (fail_count_q == FailLast) begin
                        state_d      = ST_LOCKOUT;
                        fail_count_d = '0;
                        timer_d      = LockoutLoad;
                    end else begin
                        fail_count_d = fail_count_q + CountW'(1);
                    end
                end
            end
            ST_OPEN: begin
                if (bus_if.relock || (timer_q == '0)) begin
                    state_d = ST_RELOCK;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            ST_RELOCK: begin
                state_d = ST_ARMED;
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = ST_ARMED;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            default: begin
                state_d = ST_ARMED;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_ARMED;
            fail_count_q <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            fail_count_q <= fail_count_d;
            timer_q      <= timer_d;
        end
    end

`ifdef ALARM_LATCH_EN
    logic alarm_q;

    // Sticky alarm: raised entering lockout, dropped only when the lock is opened.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            alarm_q <= 1'b0;
        end else if ((state_q != ST_LOCKOUT) && (state_d == ST_LOCKOUT)) begin
            alarm_q <= 1'b1;
        end else if ((state_q == ST_ARMED) && (state_d == ST_OPEN)) begin
            alarm_q <= 1'b0;
        end
    end

    assign bus_if.alarm = alarm_q;
`else
    assign bus_if.alarm = (state_q == ST_LOCKOUT);
`endif

    assign bus_if.key_enable = (state_q == ST_ARMED);
    assign bus_if.lock_clear = (state_q == ST_RELOCK) || (state_q == ST_LOCKOUT);
    assign bus_if.state      = state_q;
    assign bus_if.fail_count = fail_count_q;

endmodule

// File: tb/tb_lock_access_controller.sv
// Directed plus random bench for lock_access_controller; a reference model
// pushes expected outputs into a scoreboard queue that is drained after each edge.
module tb_lock_access_controller;

    localparam int unsigned MF = 3;
    localparam int unsigned LC = 16;
    localparam int unsigned OC = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lock_access_controller_if bus_if ();

    lock_access_controller #(
        .MAX_FAILS      (MF),
        .LOCKOUT_CYCLES (LC),
        .OPEN_CYCLES    (OC)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus_if  (bus_if.slave)
    );

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] fc;
        logic       ke;
        logic       lc;
        logic       al;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int   m_st = 0;
    int   m_fc = 0;
    int   m_tm = 0;
    bit   m_al = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit u, input bit f, input bit r, input bit rst);
        if (rst) begin
            m_st = 0; m_fc = 0; m_tm = 0; m_al = 1'b0;
        end else begin
            case (m_st)
                0: begin
                    if (u) begin
                        m_st = 1; m_fc = 0; m_tm = OC - 1; m_al = 1'b0;
                    end else if (f) begin
                        if (m_fc + 1 == MF) begin
                            m_st = 3; m_fc = 0; m_tm = LC - 1; m_al = 1'b1;
                        end else begin
                            m_fc++;
                        end
                    end
                end
                1: if (r || m_tm == 0) m_st = 2; else m_tm--;
                2: m_st = 0;
                default: if (m_tm == 0) m_st = 0; else m_tm--;
            endcase
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.st = 2'(m_st);
        e.fc = 2'(m_fc);
        e.ke = (m_st == 0);
        e.lc = (m_st >= 2);
`ifdef ALARM_LATCH_EN
        e.al = m_al;
`else
        e.al = (m_st == 3) | (m_al & 1'b0);
`endif
        return e;
    endfunction

    // One clock: drive inputs, predict, then compare the popped prediction.
    task automatic cycle(input bit u, input bit f, input bit r, input bit rst);
        exp_t e;
        bus_if.unlocked = u;
        bus_if.fail     = f;
        bus_if.relock   = r;
        reset           = rst;
        model_step(u, f, r, rst);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_state", 8'(bus_if.state), 8'(e.st));
        chk("sb_fail_count", 8'(bus_if.fail_count), 8'(e.fc));
        chk("sb_key_enable", 8'(bus_if.key_enable), 8'(e.ke));
        chk("sb_lock_clear", 8'(bus_if.lock_clear), 8'(e.lc));
        chk("sb_alarm", 8'(bus_if.alarm), 8'(e.al));
    endtask

    initial begin
        int n;

        // Reset
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("rst_state", 8'(bus_if.state), 8'd0);
        chk("rst_fail_count", 8'(bus_if.fail_count), 8'd0);
        chk("rst_key_enable", 8'(bus_if.key_enable), 8'd1);
        chk("rst_alarm", 8'(bus_if.alarm), 8'd0);

        // Three failures lead to lockout
        cycle(0, 1, 0, 0);
        chk("fail_count_1", 8'(bus_if.fail_count), 8'd1);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        chk("fail_count_2", 8'(bus_if.fail_count), 8'd2);
        cycle(0, 1, 0, 0);
        chk("lockout_entry", 8'(bus_if.state), 8'd3);
        chk("lockout_alarm", 8'(bus_if.alarm), 8'd1);
        chk("lockout_clear", 8'(bus_if.lock_clear), 8'd1);
        n = 0;
        while (bus_if.state === 2'b11 && n < 100) begin
            cycle((n % 4) == 1, (n % 3) == 0, (n % 2) == 0, 0);
            n++;
        end
        chk("lockout_len", 8'(n), 8'(LC));
        chk("lockout_exit_state", 8'(bus_if.state), 8'd0);
        chk("lockout_exit_fc", 8'(bus_if.fail_count), 8'd0);
`ifdef ALARM_LATCH_EN
        chk("alarm_sticky", 8'(bus_if.alarm), 8'd1);
`else
        chk("alarm_drop", 8'(bus_if.alarm), 8'd0);
`endif

        // Full open window without relock
        cycle(1, 0, 0, 0);
        chk("open_entry", 8'(bus_if.state), 8'd1);
        chk("open_key_enable", 8'(bus_if.key_enable), 8'd0);
        chk("open_alarm_clear", 8'(bus_if.alarm), 8'd0);
        n = 0;
        while (bus_if.state === 2'b01 && n < 100) begin
            cycle(0, n % 2, 0, 0);
            n++;
        end
        chk("open_len", 8'(n), 8'(OC));
        chk("relock_state", 8'(bus_if.state), 8'd2);
        chk("relock_clear", 8'(bus_if.lock_clear), 8'd1);
        cycle(0, 0, 0, 0);
        chk("relock_to_armed", 8'(bus_if.state), 8'd0);
        chk("armed_clear_low", 8'(bus_if.lock_clear), 8'd0);

        // Early relock in the second open cycle
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        chk("early_relock", 8'(bus_if.state), 8'd2);
        cycle(0, 0, 0, 0);
        chk("early_relock_armed", 8'(bus_if.state), 8'd0);

        // Unlocked beats Fail at FailCount=2
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("pre_tie_fc", 8'(bus_if.fail_count), 8'd2);
        cycle(1, 1, 0, 0);
        chk("tie_state", 8'(bus_if.state), 8'd1);
        chk("tie_fc", 8'(bus_if.fail_count), 8'd0);
        chk("tie_alarm", 8'(bus_if.alarm), 8'd0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);

        // Reset in the fifth lockout cycle
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
        chk("lockout_fail_ignored", 8'(bus_if.fail_count), 8'd0);
        chk("lockout_5th", 8'(bus_if.state), 8'd3);
        cycle(0, 0, 0, 1);
        chk("lockout_rst_state", 8'(bus_if.state), 8'd0);
        chk("lockout_rst_alarm", 8'(bus_if.alarm), 8'd0);
        cycle(0, 0, 0, 0);
        chk("post_rst_key_enable", 8'(bus_if.key_enable), 8'd1);

        // Reset during open
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        chk("open_rst_state", 8'(bus_if.state), 8'd0);

        // Random traffic checked against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 8) == 0, ($urandom % 3) == 0,
                  ($urandom % 6) == 0, ($urandom % 60) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lock_access_controller.md
LOCK_ACCESS_CONTROLLER -- requirements
Module: lock_access_controller

Interface
REQ-001 Parameter MAX_FAILS, default 3, SHALL set the number of consecutive failed attempts that trigger lockout; legal range 1..3.
REQ-002 Parameter LOCKOUT_CYCLES, default 16, SHALL set the lockout duration in clock cycles; legal range 1..256.
REQ-003 Parameter OPEN_CYCLES, default 8, SHALL set the maximum time the lock stays open in clock cycles; legal range 1..256.
REQ-004 Clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 Reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 Unlocked  input  1  SHALL indicate the combination lock is in its open state (level).
REQ-007 Fail  input  1  SHALL be a one-cycle pulse indicating the lock abandoned a partial sequence.
REQ-008 Relock  input  1  SHALL be the user request to close the lock early (level, sampled each cycle).
REQ-009 KeyEnable  output  1  SHALL gate the key buttons to the lock (1 = keys pass through).
REQ-010 LockClear  output  1  SHALL drive the lock's reset input.
REQ-011 Alarm  output  1  SHALL indicate the lockout alarm.
REQ-012 State  output  2  SHALL expose the current state: ARMED=00, OPEN=01, RELOCK=10, LOCKOUT=11.
REQ-013 FailCount  output  2  SHALL expose the current consecutive-failure count.

Function
REQ-014 State, FailCount and an 8-bit Timer SHALL be registered; KeyEnable, LockClear and Alarm SHALL be decoded from registered state only (Moore outputs, no input-to-output combinational path).
REQ-015 ARMED: KeyEnable=1, LockClear=0; Unlocked=1 -> OPEN next edge, FailCount<=0, Timer<=OPEN_CYCLES-1.
REQ-016 ARMED, Fail=1 and Unlocked=0: if FailCount+1 == MAX_FAILS -> LOCKOUT, FailCount<=0, Timer<=LOCKOUT_CYCLES-1; otherwise FailCount<=FailCount+1 and remain in ARMED.
REQ-017 ARMED, Unlocked and Fail both 1 in the same cycle: Unlocked SHALL win (-> OPEN, FailCount<=0).
REQ-018 OPEN: KeyEnable=0, LockClear=0; Relock=1 or Timer==0 -> RELOCK next edge; otherwise Timer decrements.
REQ-019 OPEN SHALL last exactly OPEN_CYCLES cycles when Relock is never asserted.
REQ-020 RELOCK: KeyEnable=0, LockClear=1 for exactly one cycle; then unconditionally -> ARMED.
REQ-021 LOCKOUT: KeyEnable=0, LockClear=1 (held), Alarm=1; Timer==0 -> ARMED next edge; otherwise Timer decrements; LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles.
REQ-022 Fail, Unlocked and Relock SHALL be ignored in LOCKOUT and RELOCK; Fail and Unlocked SHALL be ignored in OPEN.
REQ-023 The Timer SHALL never wrap: it is loaded only on entry to OPEN or LOCKOUT and is never decremented below 0.
REQ-024 FailCount SHALL saturate at MAX_FAILS-1 and SHALL never reach MAX_FAILS.

Reset
REQ-025 Reset=1 at a rising edge SHALL force, from any state, State=ARMED, FailCount=0, Timer=0 and Alarm=0, with KeyEnable=1 and LockClear=0 from the following cycle.
REQ-026 Reset SHALL take priority over every other input, including during OPEN and LOCKOUT.

Configuration
REQ-027 Macro ALARM_LATCH_EN defined: Alarm SHALL be a sticky register, set on entry to LOCKOUT and cleared only by Reset or by an ARMED -> OPEN transition.
REQ-028 Macro ALARM_LATCH_EN undefined: Alarm SHALL equal (State == LOCKOUT) and no alarm register SHALL exist.

Verification (default parameters)
REQ-029 Three Fail pulses in ARMED -> FailCount 1, 2, then LOCKOUT on the edge after the third pulse; Alarm=1 and LockClear=1 for 16 cycles; then ARMED with FailCount=0.
REQ-030 Unlocked=1 in ARMED with Relock held 0 -> OPEN for 8 cycles, KeyEnable=0; then RELOCK with a single-cycle LockClear pulse; then ARMED.
REQ-031 Relock=1 in the 2nd cycle of OPEN -> RELOCK on the next edge, then ARMED one cycle later.
REQ-032 FailCount=2 and Unlocked=Fail=1 in the same cycle -> OPEN, FailCount=0, Alarm unchanged.
REQ-033 Reset=1 in the 5th cycle of LOCKOUT -> next edge State=ARMED, FailCount=0, Alarm=0; Fail pulses during LOCKOUT leave FailCount at 0.
REQ-034 With ALARM_LATCH_EN defined: after LOCKOUT ends, Alarm stays 1 in ARMED until Unlocked=1 -> clears on the ARMED -> OPEN edge; without the macro, Alarm drops on the LOCKOUT -> ARMED edge.
